// File: rtl/sensor_pkg.sv
// Types and defaults shared by the sensor controller and the pixel readout path.
package sensor_pkg;

    typedef logic [7:0] pixel_t;

    localparam int DEFAULT_PIXEL_ARRAY_HEIGHT = 2;
    localparam int DEFAULT_PIXEL_ARRAY_WIDTH  = 2;

    // Row capture: wait for a new row, let it settle, then hold until select moves on.
    typedef enum logic [1:0] {
        CAP_WAIT,
        CAP_SETTLE,
        CAP_HELD
    } cap_state_e;

    // Pixel serializer: idle until a row is buffered, then stream its columns.
    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

endpackage

// File: rtl/row_buffer.sv
// Two-entry FIFO of captured rows; push and pop in the same cycle is legal even when full.
module row_buffer
    import sensor_pkg::*;
#(
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    // A pop frees the head slot, so a push into a full buffer succeeds alongside it.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

    // Row storage written on accepted pushes.
    // NOTE: storage has no reset; count_q alone decides which entries are valid,
    // and sequential state is always assigned with <= so all flops update together.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// Captures rows during the sensor read phase and streams them out pixel by pixel.
module pixel_readout
    import sensor_pkg::*;
#(
    parameter int PIXEL_ARRAY_HEIGHT = DEFAULT_PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_ARRAY_WIDTH  = DEFAULT_PIXEL_ARRAY_WIDTH,
    parameter int SAMPLE_DELAY       = 2,
    parameter int ROW_BITS = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
    parameter int COL_BITS = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]   p_row_select,
    input  logic [8*PIXEL_ARRAY_WIDTH-1:0]  p_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [7:0]                      out_data,
    output logic [ROW_BITS-1:0]             out_row,
    output logic [COL_BITS-1:0]             out_col,
    output logic                            out_eol,
    output logic                            out_eof,
    output logic                            overflow,
    output logic                            sel_err
);

    localparam int ENTRY_W = ROW_BITS + 8 * PIXEL_ARRAY_WIDTH;
    localparam int CNT_W   = 3;

    // Select decode
    logic [PIXEL_ARRAY_HEIGHT-1:0] sel_eff;
    logic                          sel_multi;
    logic [ROW_BITS-1:0]           sel_row;

    // Capture FSM
    cap_state_e                    cap_state_q, cap_state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [PIXEL_ARRAY_HEIGHT-1:0] cur_sel_q, cur_sel_d;
    logic [PIXEL_ARRAY_HEIGHT-1:0] last_sel_q, last_sel_d;
    logic                          cap_push;

    // Serializer FSM
    ser_state_e                    ser_state_q, ser_state_d;
    logic [COL_BITS-1:0]           col_q, col_d;
    logic                          ser_pop;

    // Buffer and sticky flags
    logic                          buf_full;
    logic                          buf_empty;
    logic [ENTRY_W-1:0]            head;
    pixel_t [PIXEL_ARRAY_WIDTH-1:0] head_pix;
    logic [ROW_BITS-1:0]           head_row;
    logic                          overflow_q, overflow_d;
    logic                          sel_err_q, sel_err_d;

    // Multi-bit selects are treated as "no row"; the row index is the set bit position.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        sel_multi = !$onehot0(p_row_select);
        sel_eff   = sel_multi ? '0 : p_row_select;
        sel_row   = '0;
        for (int r = 0; r < PIXEL_ARRAY_HEIGHT; r++) begin
            if (sel_eff[r]) sel_row = ROW_BITS'(r);
        end
    end

    // Capture FSM: settle a newly selected row, capture it once, then wait for the select to move.
    always_comb begin
        cap_state_d = cap_state_q;
        cnt_d       = cnt_q;
        cur_sel_d   = cur_sel_q;
        last_sel_d  = last_sel_q;
        cap_push    = 1'b0;
        unique case (cap_state_q)
            CAP_WAIT: begin
                if (sel_eff != '0 && sel_eff != last_sel_q) begin
                    cap_state_d = CAP_SETTLE;
                    cnt_d       = CNT_W'(1);
                    cur_sel_d   = sel_eff;
                end
            end
            CAP_SETTLE: begin
                if (sel_eff == '0) begin
                    cap_state_d = CAP_WAIT;
                end else if (sel_eff != cur_sel_q) begin
                    cnt_d     = CNT_W'(1);
                    cur_sel_d = sel_eff;
                end else if (cnt_q == CNT_W'(SAMPLE_DELAY)) begin
                    cap_push    = 1'b1;
                    last_sel_d  = cur_sel_q;
                    cap_state_d = CAP_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAP_HELD: begin
                if (sel_eff != last_sel_q) cap_state_d = CAP_WAIT;
            end
            default: cap_state_d = CAP_WAIT;
        endcase
    end

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_state_q <= CAP_WAIT;
            cnt_q       <= '0;
            cur_sel_q   <= '0;
            last_sel_q  <= '0;
        end else begin
            cap_state_q <= cap_state_d;
            cnt_q       <= cnt_d;
            cur_sel_q   <= cur_sel_d;
            last_sel_q  <= last_sel_d;
        end
    end

    row_buffer #(
        .DATA_W (ENTRY_W)
    ) u_row_buffer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (cap_push),
        .push_data_i ({sel_row, p_data}),
        .pop_i       (ser_pop),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .head_o      (head)
    );

    assign head_pix = head[8*PIXEL_ARRAY_WIDTH-1:0];
    assign head_row = head[ENTRY_W-1 -: ROW_BITS];

    // Serializer FSM: walk the head row's columns; on the last one pop and chain into the next row.
    always_comb begin
        ser_state_d = ser_state_q;
        col_d       = col_q;
        ser_pop     = 1'b0;
        unique case (ser_state_q)
            SER_IDLE: begin
                if (!buf_empty) begin
                    ser_state_d = SER_SEND;
                    col_d       = '0;
                end
            end
            SER_SEND: begin
                if (out_ready) begin
                    if (col_q == COL_BITS'(PIXEL_ARRAY_WIDTH - 1)) begin
                        ser_pop     = 1'b1;
                        col_d       = '0;
                        // After popping, a row remains if the buffer was full or one lands now.
                        ser_state_d = (buf_full || cap_push) ? SER_SEND : SER_IDLE;
                    end else begin
                        col_d = col_q + COL_BITS'(1);
                    end
                end
            end
            default: ser_state_d = SER_IDLE;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ser_state_q <= SER_IDLE;
            col_q       <= '0;
        end else begin
            ser_state_q <= ser_state_d;
            col_q       <= col_d;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_comb begin
        overflow_d = overflow_q | (cap_push & buf_full & ~ser_pop);
        sel_err_d  = sel_err_q | sel_multi;
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            sel_err_q  <= sel_err_d;
        end
    end

    // Outputs come straight from registered state, so they hold steady while stalled.
    always_comb begin
        out_valid = (ser_state_q == SER_SEND);
        out_data  = out_valid ? head_pix[col_q] : 8'h00;
        out_row   = out_valid ? head_row : '0;
        out_col   = out_valid ? col_q : '0;
        out_eol   = out_valid && (col_q == COL_BITS'(PIXEL_ARRAY_WIDTH - 1));
        out_eof   = out_eol && (head_row == ROW_BITS'(PIXEL_ARRAY_HEIGHT - 1));
        overflow  = overflow_q;
        sel_err   = sel_err_q;
    end

endmodule
